// File: rtl/seq_det_pkg.sv
// Shared types for the parametrised serial pattern detector.
package seq_det_pkg;
  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HUNT = 2'd2
  } state_e;
endpackage

// File: rtl/seq_det_cmp.sv
// Masked compare of the next history word against the loaded pattern.
module seq_det_cmp #(
  parameter int SEQ_LEN = 7
) (
  input  logic [SEQ_LEN-1:0] nhist,
  input  logic [SEQ_LEN-1:0] pattern,
  input  logic [SEQ_LEN-1:0] mask,
  output logic               hit
);
  assign hit = ~|((nhist ^ pattern) & mask);
endmodule

// File: rtl/seq_det_param.sv
// Serial bit-pattern detector with loadable pattern/mask, overlap mode,
// fill tracking and a saturating match counter.
import seq_det_pkg::*;

module seq_det_param #(
  parameter int                 SEQ_LEN = 7,
  parameter logic [SEQ_LEN-1:0] SEQ     = 7'b1110010,
  parameter logic               OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               in_valid,
  input  logic               in,
  input  logic               cfg_load,
  input  logic [SEQ_LEN-1:0] cfg_pattern,
  input  logic [SEQ_LEN-1:0] cfg_mask,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [ST_W-1:0]    state
);
  localparam int                FILL_W    = $clog2(SEQ_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(SEQ_LEN);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SEQ_LEN - 1);

  logic [SEQ_LEN-1:0] hist_q, hist_d;
  logic [SEQ_LEN-1:0] pat_q, pat_d;
  logic [SEQ_LEN-1:0] mask_q, mask_d;
  logic               ovl_q, ovl_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               out_q, out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  state_e             state_q, state_d;

  logic               accept;
  logic               hit;
  logic               match;
  logic [SEQ_LEN-1:0] nhist;

  assign accept = en & in_valid & ~cfg_load;
  assign nhist  = {hist_q[SEQ_LEN-2:0], in};
  assign match  = accept & (fill_q >= FILL_LAST) & hit;

  seq_det_cmp #(.SEQ_LEN(SEQ_LEN)) u_cmp (
    .nhist   (nhist),
    .pattern (pat_q),
    .mask    (mask_q),
    .hit     (hit)
  );

  always_comb begin
    hist_d  = hist_q;
    pat_d   = pat_q;
    mask_d  = mask_q;
    ovl_d   = ovl_q;
    fill_d  = fill_q;
    out_d   = 1'b0;
    cnt_d   = cnt_q;
    state_d = state_q;

    if (cfg_load) begin
      pat_d  = cfg_pattern;
      mask_d = cfg_mask;
      ovl_d  = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end

    if (!en) begin
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      hist_d = nhist;
      if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
      if (match) begin
        out_d = 1'b1;
        // Non-overlap: the matched bits cannot be reused by the next match.
        if (!ovl_q) begin
          hist_d = '0;
          fill_d = '0;
        end
      end
    end

    if (match && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    if (cnt_clr) cnt_d = '0;

    case (state_q)
      ST_IDLE: if (en) state_d = ST_FILL;
      ST_FILL: if (accept && (fill_q == FILL_LAST) && !(match && !ovl_q)) state_d = ST_HUNT;
      ST_HUNT: if (match && !ovl_q) state_d = ST_FILL;
      default: state_d = ST_IDLE;
    endcase
    if (cfg_load) state_d = ST_FILL;
    if (!en)      state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q  <= '0;
      pat_q   <= SEQ;
      mask_q  <= '1;
      ovl_q   <= OVERLAP;
      fill_q  <= '0;
      out_q   <= 1'b0;
      cnt_q   <= '0;
      state_q <= ST_IDLE;
    end else begin
      hist_q  <= hist_d;
      pat_q   <= pat_d;
      mask_q  <= mask_d;
      ovl_q   <= ovl_d;
      fill_q  <= fill_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign out       = out_q;
  assign match_cnt = cnt_q;
  assign state     = state_q;
endmodule
